serial_word_rx: RTL and testbench
=================================

SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 Parameter: BIT_PERIOD, default 1252, clk cycles per serial bit (10 kHz LFOSC -> ~8 bit/s); legal range 4..65535.
REQ-002 Parameter: WORD_WIDTH, default 32, data bits per frame.
REQ-003 Port: clk  input  1  system clock; one clock domain only.
REQ-004 Port: rst  input  1  reset, synchronous to clk, active-high.
REQ-005 Port: rxd  input  1  asynchronous serial line; idle high.
REQ-006 Port: data  output  WORD_WIDTH  last good received word; [31:16] is the upper 16-bit operand, [15:0] the lower.
REQ-007 Port: valid  output  1  one-cycle pulse when data has just been updated.
REQ-008 Port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 Port: busy  output  1  high in every state except IDLE.

Function
REQ-010 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs); input-to-rxs latency 2 cycles.
REQ-011 Frame SHALL be: 1 start bit (0), WORD_WIDTH data bits LSB first, 1 stop bit (1), each BIT_PERIOD cycles.
REQ-012 States SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: a 1->0 transition on rxs SHALL move to START with the bit counter (timer) cleared.
REQ-014 START: after BIT_PERIOD/2 (integer divide) cycles, rxs==0 -> DATA with timer cleared; rxs==1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: each time the timer reaches BIT_PERIOD-1, rxs SHALL be shifted into the shift register MSB end (LSB-first assembly) and the timer cleared; after WORD_WIDTH samples -> STOP.
REQ-016 STOP: at timer BIT_PERIOD-1, rxs==1 -> data <= shift register, valid=1 for exactly one cycle, -> IDLE; rxs==0 -> frame_err=1 for one cycle, data unchanged, -> WAIT_IDLE.
REQ-017 WAIT_IDLE: remain until rxs==1, then -> IDLE; a low line here SHALL never start a frame.
REQ-018 Timer SHALL be 16 bits and SHALL never wrap within a state; bit index counter SHALL be 6 bits, counting 0..WORD_WIDTH-1.
REQ-019 data SHALL hold its value between frames and across failed frames; only a good stop bit updates it.
REQ-020 valid and frame_err SHALL be mutually exclusive and never high two consecutive cycles.
REQ-021 A falling edge in the cycle valid is asserted SHALL be detected (back-to-back frames with zero idle gap are legal).

Reset
REQ-022 rst high SHALL, on the next clk edge, force state IDLE, timer 0, bit index 0, shift register 0, data 0, valid 0, frame_err 0, busy 0, both synchronizer flops 1.
REQ-023 rst asserted mid-frame SHALL abandon the frame with no valid or frame_err pulse; rst has priority over all other events.
REQ-024 After rst deasserts with rxd already low, no frame SHALL start until rxs has been seen high then falling.

Verification (BIT_PERIOD=4 for simulation)
REQ-025 Frame with data 32'h34D51531, good stop -> data==32'h34D51531, valid one cycle, frame_err never asserted.
REQ-026 Frame with data 32'hCB2BEACF, stop bit 0 -> frame_err one cycle, data retains previous value 32'h34D51531, busy stays high until rxd returns high.
REQ-027 rxd low pulse of 1 cycle while IDLE -> returns to IDLE, no valid, no frame_err, data unchanged.
REQ-028 Two frames back-to-back, 32'h0000FFFF then 32'hFFFF0000, zero gap -> two valid pulses, data sequence as sent.
REQ-029 rst pulsed at data bit 10 of a frame, then a full frame 32'h00000001 -> no pulse from the aborted frame, data==0 after reset, then data==32'h00000001 with one valid pulse.
REQ-030 Default BIT_PERIOD=1252 single frame 32'h80000001 -> valid asserted 1252*33 + 626 + 2 cycles (+/-2) after the start-bit falling edge on rxd.

Source files
------------

// File: rtl/serial_word_rx.sv
// Purpose: receives one start bit, WORD_WIDTH data bits (LSB first) and one stop bit from an async line.
// Latency: valid pulses BIT_PERIOD*(WORD_WIDTH+1) + BIT_PERIOD/2 + 2 cycles after the rxd falling edge.
// Backpressure: none; data is overwritten by each good frame and valid is a one-cycle pulse.
//
// Ports:
//   clk, rst   : single clock domain, synchronous active-high reset
//   rxd        : asynchronous serial input, idle high
//   data       : last word whose stop bit was good ([31:16] upper operand, [15:0] lower)
//   valid      : one-cycle pulse when data has just been updated
//   frame_err  : one-cycle pulse when the stop bit was sampled low
//   busy       : high whenever the receiver is not idle
module serial_word_rx #(
   parameter int unsigned BIT_PERIOD = 1252,
   parameter int unsigned WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   output logic [WORD_WIDTH-1:0] data,
   output logic                  valid,
   output logic                  frame_err,
   output logic                  busy
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);
   localparam logic [15:0] HALF_LAST = 16'(BIT_PERIOD / 2 - 1);
   localparam logic [5:0]  IDX_LAST  = 6'(WORD_WIDTH - 1);

   state_t                state, state_nxt;
   logic                  rx_meta, rxs, rx_prev;
   logic [1:0]            sync_fill;
   logic [15:0]           timer, timer_nxt;
   logic [5:0]            bit_idx, bit_idx_nxt;
   logic [WORD_WIDTH-1:0] shift, shift_nxt, data_nxt;
   logic                  valid_nxt, ferr_nxt;
   logic                  fall;

   // rx_prev only ever holds a level that really came through the synchronizer,
   // so the reset value of the sync flops can never fake a 1->0 edge when rxd
   // is already low as reset is released.
   assign fall = rx_prev & ~rxs;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         rx_prev   <= 1'b0;
         sync_fill <= 2'd0;
         state     <= IDLE;
         timer     <= 16'd0;
         bit_idx   <= 6'd0;
         shift     <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_meta   <= rxd;
         rxs       <= rx_meta;
         if (sync_fill != 2'd2) begin
            sync_fill <= sync_fill + 2'd1;
         end
         rx_prev   <= (sync_fill == 2'd2) ? rxs : 1'b0;
         state     <= state_nxt;
         timer     <= timer_nxt;
         bit_idx   <= bit_idx_nxt;
         shift     <= shift_nxt;
         data      <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      timer_nxt   = timer;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      data_nxt    = data;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      case (state)
         IDLE: begin
            timer_nxt   = 16'd0;
            bit_idx_nxt = 6'd0;
            if (fall) begin
               state_nxt = START;
            end
         end
         START: begin
            // Re-check the line half a bit in; a short low pulse is dropped silently.
            if (timer == HALF_LAST) begin
               timer_nxt = 16'd0;
               state_nxt = rxs ? IDLE : DATA;
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end
         DATA: begin
            if (timer == BIT_LAST) begin
               timer_nxt = 16'd0;
               shift_nxt = {rxs, shift[WORD_WIDTH-1:1]};
               if (bit_idx == IDX_LAST) begin
                  bit_idx_nxt = 6'd0;
                  state_nxt   = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 6'd1;
               end
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end
         STOP: begin
            if (timer == BIT_LAST) begin
               timer_nxt = 16'd0;
               if (rxs) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end else begin
               timer_nxt = timer + 16'd1;
            end
         end
         WAIT_IDLE: begin
            // A held-low line (break) must not be mistaken for a start bit.
            timer_nxt = 16'd0;
            if (rxs) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            timer_nxt = 16'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_word_rx.sv
// Purpose: self-checking bench for serial_word_rx (BIT_PERIOD=4 instance plus a default-parameter instance).
// Latency: n/a.
// Backpressure: n/a.
module tb_serial_word_rx;

   localparam int BP  = 4;
   localparam int BP2 = 1252;

   logic        clk = 1'b0;
   logic        rst, rxd, rxd2;
   logic [31:0] data, data2;
   logic        valid, frame_err, busy;
   logic        valid2, frame_err2, busy2;

   always #5 clk = ~clk;

   serial_word_rx #(.BIT_PERIOD(BP), .WORD_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .data(data),
      .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   serial_word_rx dut2 (
      .clk(clk), .rst(rst), .rxd(rxd2), .data(data2),
      .valid(valid2), .frame_err(frame_err2), .busy(busy2)
   );

   typedef struct {
      logic        is_valid;
      logic [31:0] d;
   } ev_t;

   typedef struct {
      logic [31:0] word;
      logic        stop;
      logic        exp_valid;
      logic [31:0] exp_data;
   } vec_t;

   ev_t  evq[$];
   ev_t  expq[$];
   int   checks = 0;
   int   failures = 0;
   logic prev_pulse = 1'b0;

   // Records every output pulse of the main DUT and checks the pulse rules.
   always @(negedge clk) begin
      if (valid === 1'b1 || frame_err === 1'b1) begin
         checks++;
         if ((valid && frame_err) || prev_pulse) begin
            failures++;
            $display("FAIL pulse_excl: valid=%b frame_err=%b prev_pulse=%b, required one exclusive single-cycle pulse",
                     valid, frame_err, prev_pulse);
         end
         evq.push_back('{is_valid: valid, d: data});
      end
      prev_pulse = (valid === 1'b1 || frame_err === 1'b1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rxd = b;
      tick(BP);
   endtask

   task automatic send_frame(input logic [31:0] w, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 32; i++) drive_bit(w[i]);
      drive_bit(stop);
   endtask

   vec_t vecs[6];

   initial begin
      logic [31:0] last_good;
      logic [31:0] w;
      logic        good;
      int          n;
      logic        found;

      vecs[0] = '{32'h34D51531, 1'b1, 1'b1, 32'h34D51531};
      vecs[1] = '{32'hCB2BEACF, 1'b0, 1'b0, 32'h34D51531};
      vecs[2] = '{32'h0000FFFF, 1'b1, 1'b1, 32'h0000FFFF};
      vecs[3] = '{32'hA5A5A5A5, 1'b0, 1'b0, 32'h0000FFFF};
      vecs[4] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF};
      vecs[5] = '{32'h12345678, 1'b1, 1'b1, 32'h12345678};

      // Reset state
      rst = 1'b1; rxd = 1'b1; rxd2 = 1'b1;
      tick(2);
      chk("rst_data", data, 32'h0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_ferr", frame_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_data2", data2, 32'h0);
      rst = 1'b0;
      tick(4);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         evq.delete();
         send_frame(vecs[v].word, vecs[v].stop);
         if (!vecs[v].stop) begin
            tick(3 * BP);
            chk($sformatf("v%0d_busy_low_line", v), busy, 1'b1);
         end
         rxd = 1'b1;
         tick(3 * BP);
         chk($sformatf("v%0d_pulse_count", v), evq.size(), 1);
         if (evq.size() >= 1) begin
            chk($sformatf("v%0d_pulse_kind", v), evq[0].is_valid, vecs[v].exp_valid);
            chk($sformatf("v%0d_pulse_data", v), evq[0].d, vecs[v].exp_data);
         end
         chk($sformatf("v%0d_data", v), data, vecs[v].exp_data);
         chk($sformatf("v%0d_busy_idle", v), busy, 1'b0);
      end
      last_good = 32'h12345678;

      // One-cycle glitch while idle
      evq.delete();
      rxd = 1'b0; tick(1); rxd = 1'b1;
      tick(3 * BP);
      chk("glitch_pulses", evq.size(), 0);
      chk("glitch_data", data, last_good);
      chk("glitch_busy", busy, 1'b0);

      // Back-to-back frames, zero gap
      evq.delete();
      send_frame(32'h0000FFFF, 1'b1);
      send_frame(32'hFFFF0000, 1'b1);
      tick(3 * BP);
      chk("b2b_count", evq.size(), 2);
      if (evq.size() == 2) begin
         chk("b2b_kind0", evq[0].is_valid, 1'b1);
         chk("b2b_data0", evq[0].d, 32'h0000FFFF);
         chk("b2b_kind1", evq[1].is_valid, 1'b1);
         chk("b2b_data1", evq[1].d, 32'hFFFF0000);
      end

      // Reset in the middle of a frame (at data bit 10)
      evq.delete();
      w = 32'h0F0F3C3C;
      drive_bit(1'b0);
      for (int i = 0; i < 10; i++) drive_bit(w[i]);
      rst = 1'b1;
      tick(1);
      chk("abort_data", data, 32'h0);
      chk("abort_busy", busy, 1'b0);
      rst = 1'b0; rxd = 1'b1;
      tick(3 * BP);
      chk("abort_pulses", evq.size(), 0);
      send_frame(32'h00000001, 1'b1);
      tick(3 * BP);
      chk("after_abort_count", evq.size(), 1);
      chk("after_abort_data", data, 32'h00000001);

      // Reset released with the line already low
      evq.delete();
      rxd = 1'b0; rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(6 * BP);
      chk("low_rst_busy", busy, 1'b0);
      chk("low_rst_pulses", evq.size(), 0);
      rxd = 1'b1;
      tick(4);
      send_frame(32'hDEADBEEF, 1'b1);
      tick(3 * BP);
      chk("low_rst_frame_count", evq.size(), 1);
      chk("low_rst_frame_data", data, 32'hDEADBEEF);
      last_good = 32'hDEADBEEF;

      // Randomised frames against a frame-level reference model
      evq.delete();
      expq.delete();
      for (int f = 0; f < 20; f++) begin
         w    = $urandom;
         good = ($urandom_range(0, 3) != 0);
         if (good) last_good = w;
         expq.push_back('{is_valid: good, d: last_good});
         send_frame(w, good);
         if (!good) begin
            rxd = 1'b1;
            tick(2);
         end
         n = $urandom_range(0, 6);
         if (n > 0) tick(n);
      end
      tick(3 * BP);
      chk("rand_count", evq.size(), expq.size());
      for (int i = 0; i < expq.size() && i < evq.size(); i++) begin
         chk($sformatf("rand%0d_kind", i), evq[i].is_valid, expq[i].is_valid);
         chk($sformatf("rand%0d_data", i), evq[i].d, expq[i].d);
      end
      chk("rand_final_data", data, last_good);

      // Default-parameter instance: end-to-end latency of one frame
      w = 32'h80000001;
      found = 1'b0;
      n = 0;
      fork
         begin
            rxd2 = 1'b0;
            tick(BP2);
            for (int i = 0; i < 32; i++) begin
               rxd2 = w[i];
               tick(BP2);
            end
            rxd2 = 1'b1;
            tick(BP2);
         end
         begin
            while (n < 50000 && !found) begin
               tick(1);
               n++;
               if (valid2 === 1'b1) found = 1'b1;
            end
         end
      join
      chk("long_found", found, 1'b1);
      chk("long_latency_in_window", (n >= BP2 * 33 + BP2 / 2 + 2 - 2 && n <= BP2 * 33 + BP2 / 2 + 2 + 2), 1'b1);
      chk("long_data", data2, 32'h80000001);
      chk("long_ferr", frame_err2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
